// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source encoding and entry layout for the CDB arbiter slice.
// Every file in the slice takes its widths from this package, not from local literals.
package cdb_arbiter_pkg;

  localparam int ROB_ID_WIDTH = 4;
  localparam int VAL_WIDTH    = 32;
  localparam int LAB_WIDTH    = ROB_ID_WIDTH + 1;
  localparam int ENTRY_WIDTH  = LAB_WIDTH + VAL_WIDTH;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

  typedef logic [LAB_WIDTH-1:0] lab_t;
  typedef logic [VAL_WIDTH-1:0] val_t;

  typedef struct packed {
    lab_t lab;
    val_t val;
  } cdb_entry_t;

  function automatic cdb_entry_t pack_entry(input lab_t lab, input val_t val);
    cdb_entry_t e;
    e.lab = lab;
    e.val = val;
    return e;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-producer and CDB broadcast signals of the arbiter.
// The master modport is the environment side and the slave modport is the arbiter side.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic alu_en;
  lab_t alu_lab;
  val_t alu_val;
  logic lsb_en;
  lab_t lsb_lab;
  val_t lsb_val;

  logic alu_stall;
  logic lsb_stall;
  logic cdb_en;
  lab_t cdb_lab;
  val_t cdb_val;
  logic cdb_src;
  logic overflow;

  modport master (
    output alu_en, alu_lab, alu_val,
    output lsb_en, lsb_lab, lsb_val,
    input  alu_stall, lsb_stall,
    input  cdb_en, cdb_lab, cdb_val, cdb_src,
    input  overflow
  );

  modport slave (
    input  alu_en, alu_lab, alu_val,
    input  lsb_en, lsb_lab, lsb_val,
    output alu_stall, lsb_stall,
    output cdb_en, cdb_lab, cdb_val, cdb_src,
    output overflow
  );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-source result queue: power-of-two depth, wrapping pointers, occupancy count.
// A push at a full queue is accepted only when a pop happens in the same cycle.
module result_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[head_q];

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    do_push = push && (!full || do_pop);

    if (en) begin
      if (flush) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (do_push) begin
          mem_d[tail_q] = din;
          tail_d        = tail_q + PTR_W'(1);
        end
        if (do_pop) begin
          head_d = head_q + PTR_W'(1);
        end
        // Pointers wrap naturally because DEPTH is a power of two.
        case ({do_push, do_pop})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: merges ALU and LSB results onto one registered broadcast,
// queueing the loser of each round-robin tie in a per-source FIFO.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int STALL_LEVEL = FIFO_DEPTH - 1
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  cdb_entry_t       alu_head, lsb_head;
  cdb_entry_t       alu_in, lsb_in;
  cdb_entry_t       alu_cand_entry, lsb_cand_entry;
  logic [CNT_W-1:0] alu_count, lsb_count;
  logic             alu_full, lsb_full;

  logic             active;
  logic             alu_queued, lsb_queued;
  logic             alu_cand, lsb_cand;
  logic             grant_valid;
  cdb_src_e         winner;
  logic             grant_alu, grant_lsb;
  logic             alu_push, lsb_push;
  logic             alu_pop, lsb_pop;
  logic             alu_drop, lsb_drop;

  logic             cdb_en_q, cdb_en_d;
  lab_t             cdb_lab_q, cdb_lab_d;
  val_t             cdb_val_q, cdb_val_d;
  cdb_src_e         cdb_src_q, cdb_src_d;
  cdb_src_e         last_q, last_d;
  logic             overflow_q, overflow_d;

  assign alu_in = pack_entry(bus.alu_lab, bus.alu_val);
  assign lsb_in = pack_entry(bus.lsb_lab, bus.lsb_val);

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_alu_fifo (
    .clk   (clk),
    .rst   (rst_in),
    .en    (rdy_in),
    .flush (flush),
    .push  (alu_push),
    .pop   (alu_pop),
    .din   (alu_in),
    .dout  (alu_head),
    .count (alu_count),
    .full  (alu_full)
  );

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst_in),
    .en    (rdy_in),
    .flush (flush),
    .push  (lsb_push),
    .pop   (lsb_pop),
    .din   (lsb_in),
    .dout  (lsb_head),
    .count (lsb_count),
    .full  (lsb_full)
  );

  // A queued head always outranks the same-cycle pulse so per-source order holds.
  always_comb begin
    active         = rdy_in && !flush;
    alu_queued     = (alu_count != '0);
    lsb_queued     = (lsb_count != '0);
    alu_cand       = alu_queued || bus.alu_en;
    lsb_cand       = lsb_queued || bus.lsb_en;
    alu_cand_entry = alu_queued ? alu_head : alu_in;
    lsb_cand_entry = lsb_queued ? lsb_head : lsb_in;

    grant_valid = active && (alu_cand || lsb_cand);
    if (alu_cand && lsb_cand) begin
      winner = (last_q == CDB_SRC_LSB) ? CDB_SRC_ALU : CDB_SRC_LSB;
    end else begin
      winner = alu_cand ? CDB_SRC_ALU : CDB_SRC_LSB;
    end
    grant_alu = grant_valid && (winner == CDB_SRC_ALU);
    grant_lsb = grant_valid && (winner == CDB_SRC_LSB);

    alu_pop  = grant_alu && alu_queued;
    lsb_pop  = grant_lsb && lsb_queued;
    alu_push = active && bus.alu_en && !(grant_alu && !alu_queued);
    lsb_push = active && bus.lsb_en && !(grant_lsb && !lsb_queued);
    alu_drop = alu_push && alu_full && !alu_pop;
    lsb_drop = lsb_push && lsb_full && !lsb_pop;
  end

  always_comb begin
    cdb_en_d   = cdb_en_q;
    cdb_lab_d  = cdb_lab_q;
    cdb_val_d  = cdb_val_q;
    cdb_src_d  = cdb_src_q;
    last_d     = last_q;
    overflow_d = overflow_q | alu_drop | lsb_drop;

    if (rdy_in) begin
      cdb_en_d = grant_valid;
    end
    if (grant_valid) begin
      last_d    = winner;
      cdb_src_d = winner;
      if (winner == CDB_SRC_ALU) begin
        cdb_lab_d = alu_cand_entry.lab;
        cdb_val_d = alu_cand_entry.val;
      end else begin
        cdb_lab_d = lsb_cand_entry.lab;
        cdb_val_d = lsb_cand_entry.val;
      end
    end
  end

  // Reset to LSB so the ALU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      cdb_en_q   <= 1'b0;
      cdb_lab_q  <= '0;
      cdb_val_q  <= '0;
      cdb_src_q  <= CDB_SRC_ALU;
      last_q     <= CDB_SRC_LSB;
      overflow_q <= 1'b0;
    end else begin
      cdb_en_q   <= cdb_en_d;
      cdb_lab_q  <= cdb_lab_d;
      cdb_val_q  <= cdb_val_d;
      cdb_src_q  <= cdb_src_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.cdb_en    = cdb_en_q;
  assign bus.cdb_lab   = cdb_lab_q;
  assign bus.cdb_val   = cdb_val_q;
  assign bus.cdb_src   = cdb_src_q;
  assign bus.overflow  = overflow_q;
  assign bus.alu_stall = (alu_count >= CNT_W'(STALL_LEVEL));
  assign bus.lsb_stall = (lsb_count >= CNT_W'(STALL_LEVEL));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-derived grant orders, stall levels, overflow,
// flush and rdy_in freeze, each checked with an immediate assertion.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  cdb_arbiter_if bus();

  cdb_arbiter #(
    .FIFO_DEPTH  (4),
    .STALL_LEVEL (3)
  ) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ALU values are 0xA000+label and LSB values 0xB000+label so value checks follow the label.
  task automatic apply_stimulus(input logic a_en, input int a_lab, input logic l_en, input int l_lab);
    bus.alu_en  = a_en;
    bus.alu_lab = LAB_WIDTH'(a_lab);
    bus.alu_val = VAL_WIDTH'(32'hA000 + a_lab);
    bus.lsb_en  = l_en;
    bus.lsb_lab = LAB_WIDTH'(l_lab);
    bus.lsb_val = VAL_WIDTH'(32'hB000 + l_lab);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cdb(input string tag, input logic exp_en, input int exp_lab, input logic exp_src);
    logic [31:0] exp_val;
    exp_val = exp_src ? 32'(32'hB000 + exp_lab) : 32'(32'hA000 + exp_lab);
    check_output({tag, "_en"},  32'(bus.cdb_en),  32'(exp_en));
    check_output({tag, "_lab"}, 32'(bus.cdb_lab), 32'(exp_lab));
    check_output({tag, "_val"}, 32'(bus.cdb_val), exp_val);
    check_output({tag, "_src"}, 32'(bus.cdb_src), 32'(exp_src));
  endtask

  task automatic check_stalls(input string tag, input logic exp_alu, input logic exp_lsb);
    check_output({tag, "_alu_stall"}, 32'(bus.alu_stall), 32'(exp_alu));
    check_output({tag, "_lsb_stall"}, 32'(bus.lsb_stall), 32'(exp_lsb));
  endtask

  initial begin
    int alu_cnt_exp [17] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 4, 3, 3, 2, 2, 1, 1, 0};
    int lsb_cnt_exp [17] = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0};

    rst_in = 1'b1;
    rdy_in = 1'b1;
    flush  = 1'b0;
    apply_stimulus(1'b0, 0, 1'b0, 0);
    tick();
    tick();
    check_output("rst_cdb_en", 32'(bus.cdb_en), 32'd0);
    check_output("rst_cdb_lab", 32'(bus.cdb_lab), 32'd0);
    check_output("rst_cdb_val", 32'(bus.cdb_val), 32'd0);
    check_output("rst_cdb_src", 32'(bus.cdb_src), 32'd0);
    check_output("rst_overflow", 32'(bus.overflow), 32'd0);
    check_stalls("rst", 1'b0, 1'b0);
    rst_in = 1'b0;
    tick();

    // Single uncontended ALU result: visible exactly one cycle later, then cdb_en drops.
    apply_stimulus(1'b1, 5, 1'b0, 0);
    bus.alu_val = 32'h1234;
    tick();
    apply_stimulus(1'b0, 0, 1'b0, 0);
    check_output("single_en", 32'(bus.cdb_en), 32'd1);
    check_output("single_lab", 32'(bus.cdb_lab), 32'd5);
    check_output("single_val", 32'(bus.cdb_val), 32'h1234);
    check_output("single_src", 32'(bus.cdb_src), 32'd0);
    tick();
    check_output("single_after_en", 32'(bus.cdb_en), 32'd0);
    check_output("single_hold_lab", 32'(bus.cdb_lab), 32'd5);
    check_output("single_hold_val", 32'(bus.cdb_val), 32'h1234);

    // Simultaneous results right after reset: ALU wins the first tie.
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    apply_stimulus(1'b1, 3, 1'b1, 7);
    tick();
    apply_stimulus(1'b0, 0, 1'b0, 0);
    check_cdb("simul_first", 1'b1, 3, 1'b0);
    tick();
    check_cdb("simul_second", 1'b1, 7, 1'b1);
    tick();
    check_output("simul_idle_en", 32'(bus.cdb_en), 32'd0);
    check_output("simul_overflow", 32'(bus.overflow), 32'd0);

    // Contended burst: ALU 9..12 and LSB 1..4 on four cycles, strict alternation.
    for (int i = 0; i < 8; i++) begin
      if (i < 4) apply_stimulus(1'b1, 9 + i, 1'b1, 1 + i);
      else       apply_stimulus(1'b0, 0, 1'b0, 0);
      tick();
      if (i % 2 == 0) check_cdb($sformatf("burst%0d", i), 1'b1, 9 + i / 2, 1'b0);
      else            check_cdb($sformatf("burst%0d", i), 1'b1, 1 + i / 2, 1'b1);
      check_stalls($sformatf("burst%0d", i), 1'b0, 1'b0);
    end
    apply_stimulus(1'b0, 0, 1'b0, 0);
    tick();
    check_output("burst_idle_en", 32'(bus.cdb_en), 32'd0);

    // Both sources fire for nine cycles; on the ninth the LSB queue is full and label 9 is lost.
    for (int i = 0; i < 17; i++) begin
      if (i <= 8) apply_stimulus(1'b1, 17 + i, 1'b1, 1 + i);
      else        apply_stimulus(1'b0, 0, 1'b0, 0);
      tick();
      if (i % 2 == 0) check_cdb($sformatf("ovf%0d", i), 1'b1, 17 + i / 2, 1'b0);
      else            check_cdb($sformatf("ovf%0d", i), 1'b1, 1 + i / 2, 1'b1);
      check_stalls($sformatf("ovf%0d", i), alu_cnt_exp[i] >= 3, lsb_cnt_exp[i] >= 3);
      check_output($sformatf("ovf%0d_flag", i), 32'(bus.overflow), 32'(i >= 8));
    end
    apply_stimulus(1'b0, 0, 1'b0, 0);
    tick();
    check_output("ovf_idle_en", 32'(bus.cdb_en), 32'd0);
    check_output("ovf_idle_lab", 32'(bus.cdb_lab), 32'd25);
    check_output("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Last grant was ALU, so this fill starts with LSB and leaves three entries per queue.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 20 + i, 1'b1, 10 + i);
      tick();
      if (i % 2 == 0) check_cdb($sformatf("fill%0d", i), 1'b1, 10 + i / 2, 1'b1);
      else            check_cdb($sformatf("fill%0d", i), 1'b1, 20 + i / 2, 1'b0);
    end
    check_stalls("fill_full", 1'b1, 1'b1);

    flush = 1'b1;
    apply_stimulus(1'b1, 26, 1'b1, 16);
    tick();
    flush = 1'b0;
    apply_stimulus(1'b0, 0, 1'b0, 0);
    check_output("flush_en", 32'(bus.cdb_en), 32'd0);
    check_output("flush_hold_lab", 32'(bus.cdb_lab), 32'd22);
    check_output("flush_keeps_overflow", 32'(bus.overflow), 32'd1);
    check_stalls("flush", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output($sformatf("flush_quiet%0d", i), 32'(bus.cdb_en), 32'd0);
    end

    // Round-robin state survives the flush: last was ALU, so LSB wins this tie.
    apply_stimulus(1'b1, 21, 1'b1, 11);
    tick();
    apply_stimulus(1'b0, 0, 1'b0, 0);
    check_cdb("post_flush_lsb", 1'b1, 11, 1'b1);
    tick();
    check_cdb("post_flush_alu", 1'b1, 21, 1'b0);

    // Queue one entry per source, then freeze with rdy_in low while new pulses arrive.
    apply_stimulus(1'b1, 22, 1'b1, 12);
    tick();
    check_cdb("pre_freeze0", 1'b1, 12, 1'b1);
    apply_stimulus(1'b1, 23, 1'b1, 13);
    tick();
    check_cdb("pre_freeze1", 1'b1, 22, 1'b0);
    rdy_in = 1'b0;
    apply_stimulus(1'b1, 24, 1'b1, 14);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_cdb($sformatf("freeze%0d", i), 1'b1, 22, 1'b0);
    end
    rdy_in = 1'b1;
    apply_stimulus(1'b0, 0, 1'b0, 0);
    tick();
    check_cdb("thaw0", 1'b1, 13, 1'b1);
    tick();
    check_cdb("thaw1", 1'b1, 23, 1'b0);
    tick();
    check_output("thaw_idle_en", 32'(bus.cdb_en), 32'd0);
    tick();
    check_output("thaw_idle2_en", 32'(bus.cdb_en), 32'd0);

    // Reset with rdy_in low clears outputs and the queued ALU label 25.
    apply_stimulus(1'b1, 25, 1'b1, 15);
    tick();
    check_cdb("pre_reset", 1'b1, 15, 1'b1);
    check_output("pre_reset_overflow", 32'(bus.overflow), 32'd1);
    rdy_in = 1'b0;
    rst_in = 1'b1;
    apply_stimulus(1'b0, 0, 1'b0, 0);
    tick();
    check_output("rst2_cdb_en", 32'(bus.cdb_en), 32'd0);
    check_output("rst2_cdb_lab", 32'(bus.cdb_lab), 32'd0);
    check_output("rst2_cdb_val", 32'(bus.cdb_val), 32'd0);
    check_output("rst2_cdb_src", 32'(bus.cdb_src), 32'd0);
    check_output("rst2_overflow", 32'(bus.overflow), 32'd0);
    check_stalls("rst2", 1'b0, 1'b0);
    rst_in = 1'b0;
    rdy_in = 1'b1;
    tick();
    check_output("rst2_after_en", 32'(bus.cdb_en), 32'd0);
    check_output("rst2_after_lab", 32'(bus.cdb_lab), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
